// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Combinational helpers only; no flow control.
package uart_rx_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int PRESCALE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic prescale_legal(input int unsigned p);
        return (p == 8) || (p == 16) || (p == 32);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, frame-format controls and received-byte strobes of the UART receiver.
// master drives the line and format controls; slave is the receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  par_en;
    logic                  par_typ;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output rx_in, prescale, par_en, par_typ,
        input  p_data, data_valid, par_err, stp_err
    );

    modport slave (
        input  rx_in, prescale, par_en, par_typ,
        output p_data, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and bit counter; flags the wrap and the bit-resolve point.
// Resolve point is e==P/2, or e==P/2+1 when UART_RX_MAJORITY_VOTE_EN is defined. No backpressure.
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] presc_i,
    input  logic                  cnt_en_i,
    input  logic                  cnt_clr_i,
    input  logic                  bit_clr_i,
    output logic                  wrap_o,
    output logic                  res_o,
    output logic [BIT_W-1:0]      bit_o
);
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [PRESCALE_W-1:0] half;

    assign half   = presc_i >> 1;
    assign wrap_o = cnt_en_i && (edge_q == presc_i - PRESCALE_W'(1));
`ifdef UART_RX_MAJORITY_VOTE_EN
    assign res_o  = cnt_en_i && (edge_q == half + PRESCALE_W'(1));
`else
    assign res_o  = cnt_en_i && (edge_q == half);
`endif
    assign bit_o  = bit_q;

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (cnt_clr_i) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (cnt_en_i) begin
            if (wrap_o) begin
                edge_d = '0;
                bit_d  = bit_clr_i ? '0 : bit_q + BIT_W'(1);
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start, DATA_WIDTH data bits LSB first, optional parity, 1 stop.
// Strobes appear 2 sync cycles + mid-stop-bit after the start edge (+1 with UART_RX_MAJORITY_VOTE_EN); no backpressure.
module uart_rx #(
    parameter int DATA_WIDTH = uart_rx_pkg::DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave rx
);
    import uart_rx_pkg::*;

    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    logic                  sync1_q, rx_s_q;
    rx_state_e             state_q, state_d;
    logic                  armed_q, armed_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic                  wrap, res_pt, bit_val, par_mis, last_bit;
    logic [BIT_W-1:0]      bit_cnt;

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .presc_i   (presc_q),
        .cnt_en_i  (state_q != IDLE),
        .cnt_clr_i (state_q == IDLE),
        .bit_clr_i (state_q == START),
        .wrap_o    (wrap),
        .res_o     (res_pt),
        .bit_o     (bit_cnt)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // hist_q holds rx_s from the two cycles before the resolve point
    logic [1:0] hist_q;
    always_ff @(posedge clk) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= {hist_q[0], rx_s_q};
    end
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    assign bit_val = rx_s_q;
`endif

    assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign par_mis  = par_en_q && (par_bit_q != ((^shift_q) ^ par_typ_q));

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        p_data_d  = p_data_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // After a frame or glitch the line must be seen high once before a new start
                if (!armed_q) begin
                    armed_d = rx_s_q;
                end else if (!rx_s_q) begin
                    state_d   = START;
                    presc_d   = prescale_legal(32'(rx.prescale)) ? rx.prescale
                                                                 : PRESCALE_W'(PRESCALE_DEFAULT);
                    par_en_d  = rx.par_en;
                    par_typ_d = rx.par_typ;
                end
            end
            START: begin
                if (res_pt && bit_val) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (res_pt) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                if (wrap && last_bit) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (res_pt) par_bit_d = bit_val;
                if (wrap)   state_d   = STOP;
            end
            STOP: begin
                if (res_pt) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                    pe_d    = par_mis;
                    se_d    = !bit_val;
                    if (!par_mis && bit_val) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            presc_q   <= PRESCALE_W'(PRESCALE_DEFAULT);
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            sync1_q   <= rx.rx_in;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            armed_q   <= armed_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end

    assign rx.p_data     = p_data_q;
    assign rx.data_valid = dv_q;
    assign rx.par_err    = pe_q;
    assign rx.stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames from the test plan plus randomized frames
// scored against a frame-level outcome model.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) rx_if ();

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx_if.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: counts strobes, records received bytes, flags strobes wider than 1 cycle
    int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0, wide_cnt = 0;
    logic [7:0] rx_q[$];
    logic       dv_prev = 1'b0, pe_prev = 1'b0, se_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_if.data_valid === 1'b1) begin
            dv_cnt++;
            rx_q.push_back(rx_if.p_data);
        end
        if (rx_if.par_err === 1'b1) pe_cnt++;
        if (rx_if.stp_err === 1'b1) se_cnt++;
        if ((rx_if.data_valid && dv_prev) || (rx_if.par_err && pe_prev) ||
            (rx_if.stp_err && se_prev))
            wide_cnt++;
        dv_prev = rx_if.data_valid;
        pe_prev = rx_if.par_err;
        se_prev = rx_if.stp_err;
    end

    logic [7:0] model_pdata = 8'h00;
    int         snap_dv, snap_pe, snap_se;

    function automatic int bit_time(input int p);
        return (p == 8 || p == 16 || p == 32) ? p : 16;
    endfunction

    task automatic idle(input int n);
        rx_if.rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int n, input int glitch_at);
        for (int c = 0; c < n; c++) begin
            rx_if.rx_in = (c == glitch_at) ? ~v : v;
            @(negedge clk);
        end
    endtask

    // Drives one frame; config is scrambled after the start bit to prove it is frozen.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                              input logic pbit, input logic stop, input int glitch_bit);
        int tim;
        tim = bit_time(p);
        rx_if.prescale = 6'(p);
        rx_if.par_en   = pen;
        rx_if.par_typ  = ptyp;
        drive_bit(1'b0, tim, -1);
        rx_if.prescale = 6'($urandom);
        rx_if.par_en   = 1'($urandom);
        rx_if.par_typ  = 1'($urandom);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i], tim, (i == glitch_bit) ? tim / 2 + 1 : -1);
        if (pen) drive_bit(pbit, tim, -1);
        drive_bit(stop, tim, -1);
    endtask

    task automatic snapshot();
        snap_dv = dv_cnt;
        snap_pe = pe_cnt;
        snap_se = se_cnt;
    endtask

    task automatic check_counts(input string tag, input int edv, input int epe, input int ese);
        check_eq({tag, ".dv"}, 32'(dv_cnt - snap_dv), 32'(edv));
        check_eq({tag, ".pe"}, 32'(pe_cnt - snap_pe), 32'(epe));
        check_eq({tag, ".se"}, 32'(se_cnt - snap_se), 32'(ese));
        check_eq({tag, ".pdata"}, 32'(rx_if.p_data), 32'(model_pdata));
    endtask

    // Frame-level model: outcome follows from the parity rule and the stop bit alone
    task automatic run_frame(input string tag, input logic [7:0] d, input int p, input logic pen,
                             input logic ptyp, input logic pbit_ok, input logic stop,
                             input int glitch_bit, input int gap);
        logic pbit, exp_pe, exp_se, exp_dv;
        pbit   = (^d) ^ ptyp;
        if (!pbit_ok) pbit = ~pbit;
        exp_pe = pen && !pbit_ok;
        exp_se = !stop;
        exp_dv = !exp_pe && !exp_se;
        snapshot();
        send_frame(d, p, pen, ptyp, pbit, stop, glitch_bit);
        idle(gap);
        if (exp_dv) model_pdata = d;
        check_counts(tag, int'(exp_dv), int'(exp_pe), int'(exp_se));
        if (exp_dv && rx_q.size() > 0)
            check_eq({tag, ".byte"}, 32'(rx_q[rx_q.size()-1]), 32'(d));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gb;
        int p;
        logic [7:0] d;
        rst            = 1'b1;
        rx_if.rx_in    = 1'b1;
        rx_if.prescale = 6'd16;
        rx_if.par_en   = 1'b0;
        rx_if.par_typ  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset.pdata", 32'(rx_if.p_data), 32'h0);
        check_eq("reset.dv", 32'(rx_if.data_valid), 32'h0);
        check_eq("reset.pe", 32'(rx_if.par_err), 32'h0);
        check_eq("reset.se", 32'(rx_if.stp_err), 32'h0);
        rst = 1'b0;
        idle(5);

        run_frame("p8_a5", 8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, -1, 6);
        run_frame("p16_even_ok", 8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 8);
        run_frame("p16_even_bad", 8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 8);
        run_frame("p32_odd_stop0", 8'h01, 32, 1'b1, 1'b1, 1'b1, 1'b0, -1, 10);

        // Start glitch: 2 low cycles must not produce anything
        snapshot();
        rx_if.prescale = 6'd16;
        rx_if.par_en   = 1'b0;
        drive_bit(1'b0, 2, -1);
        idle(40);
        check_counts("glitch", 0, 0, 0);
        run_frame("after_glitch", 8'h5A, 16, 1'b0, 1'b0, 1'b1, 1'b1, -1, 8);

        // Back-to-back frames with no idle gap
        snapshot();
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(6);
        model_pdata = 8'hFF;
        check_counts("b2b", 2, 0, 0);
        if (rx_q.size() >= 2) begin
            check_eq("b2b.first", 32'(rx_q[rx_q.size()-2]), 32'h00);
            check_eq("b2b.second", 32'(rx_q[rx_q.size()-1]), 32'hFF);
        end else begin
            check_eq("b2b.qsize", 32'(rx_q.size()), 32'd2);
        end

        // Reset in the middle of the data bits
        snapshot();
        rx_if.prescale = 6'd16;
        rx_if.par_en   = 1'b0;
        d = 8'h6B;
        drive_bit(1'b0, 16, -1);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 16, -1);
        rst         = 1'b1;
        rx_if.rx_in = 1'b1;
        @(negedge clk);
        check_eq("rst_mid.pdata", 32'(rx_if.p_data), 32'h0);
        check_eq("rst_mid.strobes",
                 32'({rx_if.data_valid, rx_if.par_err, rx_if.stp_err}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_pdata = 8'h00;
        idle(40);
        check_counts("rst_mid.quiet", 0, 0, 0);
`ifdef UART_RX_MAJORITY_VOTE_EN
        gb = 2;
`else
        gb = -1;
`endif
        run_frame("after_rst_96", 8'h96, 16, 1'b0, 1'b0, 1'b1, 1'b1, gb, 8);

        // Break: one stop error, then silence until the line returns high
        snapshot();
        rx_if.prescale = 6'd16;
        rx_if.par_en   = 1'b0;
        drive_bit(1'b0, 16 * 14, -1);
        idle(20);
        check_counts("break", 0, 0, 1);
        run_frame("after_break", 8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b1, -1, 8);

        // Illegal prescale falls back to 16x timing
        run_frame("illegal_p12", 8'hC3, 12, 1'b1, 1'b1, 1'b1, 1'b1, -1, 8);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            run_frame($sformatf("rand%0d", n), 8'($urandom), p, 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), -1,
                      $urandom_range(4, 20));
        end

        check_eq("strobe_width", 32'(wide_cnt), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Oversampling UART receiver, the receive-side counterpart of our UART transmitter. It recovers frames of 1 start bit, 8 data bits (LSB first), an optional parity bit and 1 stop bit from serial line rx_in. It presents each good byte as p_data with a one-cycle data_valid strobe, and flags parity and stop (framing) errors. Line format controls par_en/par_typ match the transmitter (par_typ 0 = even, 1 = odd).

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of prescale input and oversample edge counter

Ports:
clk  input  1  single system clock (oversample clock = prescale x baud)
rst  input  1  synchronous, active-high reset
rx_in  input  1  serial line, idle high, asynchronous to clk
prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
par_en  input  1  1 = parity bit present
par_typ  input  1  0 = even, 1 = odd
p_data  output  DATA_WIDTH  last correctly received byte
data_valid  output  1  one-cycle pulse, p_data updated this cycle
par_err  output  1  one-cycle pulse, parity mismatch in the frame just ended
stp_err  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising clk).
- Reset values: p_data=0, data_valid=0, par_err=0, stp_err=0, state=IDLE, counters=0, synchronizer flops=1. Reset mid-frame aborts the frame with no strobes.
- rx_in passes through a 2-flop synchronizer (rx_s); all logic uses rx_s. This adds 2 cycles of latency.
- prescale, par_en and par_typ are latched on the start-bit falling edge and are frozen for the frame. An illegal prescale is treated as 16.
- Edge counter e: 0..P-1, resets to 0 on start detect, wraps to 0 at P-1. The bit counter b increments on each wrap.
- Sample point: sample = rx_s at e==P/2. With majority voting (see Optional Feature), the bit value is resolved at e==P/2+1.
- FSM states are IDLE, START, DATA, PARITY, STOP:
  - IDLE: rx_s==0 -> START, e=0.
  - START: at the sample point, a sampled 1 is a glitch -> IDLE, no strobes. A sampled 0 waits for the wrap -> DATA, b=0.
  - DATA: each sample is shifted in LSB first. At the wrap of bit 7 -> PARITY if par_en, else STOP.
  - PARITY: sample the bit and compute the expected parity = XOR(data) ^ par_typ. At the wrap -> STOP.
  - STOP: at the sample point, evaluate the frame and go -> IDLE immediately (mid-stop bit), so a start bit following back-to-back is caught.
- Frame evaluation happens in the cycle after the stop sample point:
  - stop==1 and no parity mismatch: p_data <= shift register, data_valid=1.
  - parity mismatch: par_err=1, p_data unchanged, no data_valid.
  - stop==0: stp_err=1, p_data unchanged, no data_valid.
  - Both errors can pulse in the same cycle.
- All strobes are exactly 1 cycle wide. p_data holds its value between frames.
- A line held low (break) gives stp_err, then the FSM waits in IDLE for rx_s to return to 1 before accepting a new start. An IDLE-entry flag must see rx_s==1 once before start detection is re-armed.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN
- Defined: the bit value is the 2-of-3 majority of rx_s at e = P/2-1, P/2, P/2+1, resolved at P/2+1. Evaluation latency shifts by 1 cycle.
- Undefined: a single sample at e==P/2. Both variants give identical results on a clean line.

Decomposition:
- Package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP), constants PRESCALE_DEFAULT=16, DATA_WIDTH=8, and the legal-prescale check function.
- One natural sub-module, uart_rx_edge_bit_cnt: holds the edge and bit counters, enable/clear inputs and wrap/sample-point outputs.
- FSM, sampler, deserializer and checker stay in uart_rx.

Test Plan:
- prescale=8, par_en=0, frame 0xA5 -> p_data=0xA5, data_valid exactly one cycle; par_err=0, stp_err=0.
- prescale=16, par_en=1, par_typ=0, 0x3C with parity bit 0 -> data_valid, p_data=0x3C. Same frame with parity bit 1 -> par_err pulse, no data_valid, p_data keeps 0x3C.
- prescale=32, par_en=1, par_typ=1, 0x01 with correct parity bit 0, stop bit 0 -> stp_err pulse only.
- Start glitch: rx_in low for 2 cycles at prescale=16 -> return to IDLE, no strobes. A following valid 0x5A is received correctly.
- Back-to-back frames 0x00, 0xFF with no idle gap, prescale=8 -> two data_valid pulses, values 0x00 then 0xFF.
- rst asserted during DATA of a frame -> all outputs 0 next cycle. The next full frame 0x96 is received correctly; with the macro defined, a 1-sample mid-bit glitch still yields 0x96.
